sdram_avm_mport_bridge: RTL and testbench

Parametrised multi-port bridge from narrow client ports to one Avalon-MM SDRAM master interface.
- Packs DATA_W-bit client accesses into AVM_DATA_W-bit SDRAM words using lane byte-enables.
- Arbitrates NUM_PORTS clients round-robin.
- Pipelines reads with up to MAX_PENDING outstanding, routing each return to its issuing port.
- Replaces single-port, single-outstanding, inout-data access to the SDRAM controller.

---
 rtl/sdram_avm_mport_bridge.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sdram_avm_mport_bridge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_avm_mport_bridge.sv
// ---------------------------------------------------------------------------
// sdram_avm_mport_bridge
// Multi-port bridge from narrow client ports to a single Avalon-MM SDRAM
// master. Client accesses are placed into one lane of the wide SDRAM word
// with lane byte-enables. Clients are arbitrated round-robin. Reads are
// pipelined with up to MAX_PENDING outstanding, and each return is steered
// to the port that issued it.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req/i_we/i_addr/i_wdata   per-port request, slice p belongs to port p
//   o_ready                 combinational accept strobe (one-hot or zero)
//   o_wdone                 1-cycle pulse when a port's write is taken by SDRAM
//   o_rvalid/o_rdata        1-cycle per-port pulse with shared read data
//   o_err                   sticky: readdatavalid seen with nothing outstanding
//   o_avm_* / i_avm_*       Avalon-MM master towards the SDRAM controller
// ---------------------------------------------------------------------------
module sdram_avm_mport_bridge #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned AVM_DATA_W  = 32,
    parameter int unsigned ADDR_W      = 26,
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic                                                 i_clk,
    input  logic                                                 i_rst_n,
    input  logic [NUM_PORTS-1:0]                                 i_req,
    input  logic [NUM_PORTS-1:0]                                 i_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]                          i_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]                          i_wdata,
    output logic [NUM_PORTS-1:0]                                 o_ready,
    output logic [NUM_PORTS-1:0]                                 o_wdone,
    output logic [NUM_PORTS-1:0]                                 o_rvalid,
    output logic [DATA_W-1:0]                                    o_rdata,
    output logic                                                 o_err,
    output logic [ADDR_W-((AVM_DATA_W/DATA_W > 1) ? $clog2(AVM_DATA_W/DATA_W) : 0)-1:0] o_avm_address,
    output logic [AVM_DATA_W/8-1:0]                              o_avm_byteenable,
    output logic                                                 o_avm_chipselect,
    output logic [AVM_DATA_W-1:0]                                o_avm_writedata,
    output logic                                                 o_avm_read,
    output logic                                                 o_avm_write,
    input  logic [AVM_DATA_W-1:0]                                i_avm_readdata,
    input  logic                                                 i_avm_readdatavalid,
    input  logic                                                 i_avm_waitrequest
);

    localparam int unsigned LANES   = AVM_DATA_W / DATA_W;
    localparam int unsigned LANE_W  = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int unsigned LANE_WS = (LANE_W > 0) ? LANE_W : 1;
    localparam int unsigned PID_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned BE_W    = AVM_DATA_W / 8;
    localparam int unsigned LANE_BE = DATA_W / 8;
    localparam int unsigned WADDR_W = ADDR_W - LANE_W;
    localparam int unsigned PTR_W   = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int unsigned CNT_W   = $clog2(MAX_PENDING + 1);

    // Command slot (the Avalon outputs are the slot registers themselves)
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [WADDR_W-1:0]    waddr_q, waddr_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic [AVM_DATA_W-1:0] wdata_q, wdata_d;
    logic [PID_W-1:0]      slot_port_q, slot_port_d;

    // Arbiter, completion and read-tracking state
    logic [PID_W-1:0]      rr_q, rr_d;
    logic [NUM_PORTS-1:0]  wdone_q, wdone_d;
    logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PID_W-1:0]      tag_port_q [MAX_PENDING];
    logic [LANE_WS-1:0]    tag_lane_q [MAX_PENDING];

    // Arbitration / selection signals
    logic [NUM_PORTS-1:0]  elig;
    logic                  win_found;
    logic [PID_W-1:0]      win;
    logic                  rd_room;
    logic                  slot_free;
    logic                  retire;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic [LANE_WS-1:0]    sel_lane;
    logic                  push;
    logic                  pop;
    logic [PID_W-1:0]      rd_port;
    logic [LANE_WS-1:0]    rd_lane;

    assign rd_room   = (cnt_q < CNT_W'(MAX_PENDING));
    assign retire    = (rd_q | wr_q) & ~i_avm_waitrequest;
    assign slot_free = ~(rd_q | wr_q) | retire;

    // Round-robin pick: first eligible port at or after the pointer
    always_comb begin
        int unsigned k;
        k         = 0;
        elig      = '0;
        win_found = 1'b0;
        win       = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            elig[p] = i_req[p] & (i_we[p] | rd_room);
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            k = 32'(rr_q) + i;
            if (k >= NUM_PORTS) begin
                k = k - NUM_PORTS;
            end
            if (!win_found && elig[PID_W'(k)]) begin
                win_found = 1'b1;
                win       = PID_W'(k);
            end
        end
    end

    assign accept  = win_found & slot_free;
    assign o_ready = accept ? (NUM_PORTS'(1) << win) : '0;

    // Mux out the winning port's request fields
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (PID_W'(p) == win) begin
                sel_we   = i_we[p];
                sel_addr = i_addr[p*ADDR_W +: ADDR_W];
                sel_data = i_wdata[p*DATA_W +: DATA_W];
            end
        end
    end

    // Lane index within the SDRAM word; a single-lane word has only lane 0
    generate
        if (LANE_W > 0) begin : g_lane
            assign sel_lane = sel_addr[LANE_W-1:0];
        end else begin : g_nolane
            assign sel_lane = '0;
        end
    endgenerate

    assign push    = accept & ~sel_we;
    assign pop     = i_avm_readdatavalid & (cnt_q != '0);
    assign rd_port = tag_port_q[rptr_q];
    assign rd_lane = tag_lane_q[rptr_q];

    // Next-state logic for slot, arbiter pointer, completions and read tracking
    always_comb begin
        rd_d        = rd_q;
        wr_d        = wr_q;
        waddr_d     = waddr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        slot_port_d = slot_port_q;
        rr_d        = rr_q;
        wdone_d     = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;

        if (accept) begin
            rd_d        = ~sel_we;
            wr_d        = sel_we;
            waddr_d     = sel_addr[ADDR_W-1:LANE_W];
            be_d        = BE_W'({LANE_BE{1'b1}}) << (sel_lane * LANE_BE);
            wdata_d     = sel_we ? (AVM_DATA_W'(sel_data) << (sel_lane * DATA_W)) : '0;
            slot_port_d = win;
            rr_d        = (win == PID_W'(NUM_PORTS - 1)) ? '0 : PID_W'(win + 1'b1);
        end else if (retire) begin
            rd_d = 1'b0;
            wr_d = 1'b0;
        end

        if (wr_q && !i_avm_waitrequest) begin
            wdone_d = NUM_PORTS'(1) << slot_port_q;
        end

        if (push) begin
            wptr_d = (wptr_q == PTR_W'(MAX_PENDING - 1)) ? '0 : PTR_W'(wptr_q + 1'b1);
        end

        if (pop) begin
            rptr_d   = (rptr_q == PTR_W'(MAX_PENDING - 1)) ? '0 : PTR_W'(rptr_q + 1'b1);
            rvalid_d = NUM_PORTS'(1) << rd_port;
            rdata_d  = DATA_W'(i_avm_readdata >> (rd_lane * DATA_W));
        end

        // A return with nothing outstanding is flagged and otherwise dropped
        if (i_avm_readdatavalid && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            waddr_q     <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            slot_port_q <= '0;
            rr_q        <= '0;
            wdone_q     <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            waddr_q     <= waddr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            slot_port_q <= slot_port_d;
            rr_q        <= rr_d;
            wdone_q     <= wdone_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
        end
    end

    // Read tag FIFO storage: {port, lane} of each accepted read, in order
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MAX_PENDING; i++) begin
                tag_port_q[i] <= '0;
                tag_lane_q[i] <= '0;
            end
        end else if (push) begin
            tag_port_q[wptr_q] <= win;
            tag_lane_q[wptr_q] <= sel_lane;
        end
    end

    assign o_avm_read       = rd_q;
    assign o_avm_write      = wr_q;
    assign o_avm_address    = waddr_q;
    assign o_avm_byteenable = be_q;
    assign o_avm_writedata  = wdata_q;
    assign o_avm_chipselect = 1'b1;
    assign o_wdone          = wdone_q;
    assign o_rvalid         = rvalid_q;
    assign o_rdata          = rdata_q;
    assign o_err            = err_q;

endmodule

// File: tb/tb_sdram_avm_mport_bridge.sv
// ---------------------------------------------------------------------------
// tb_sdram_avm_mport_bridge
// Directed bench for sdram_avm_mport_bridge with default parameters
// (16-bit clients, 32-bit SDRAM word, 2 ports, 4 outstanding reads).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sdram_avm_mport_bridge;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned AVM_DATA_W  = 32;
    localparam int unsigned ADDR_W      = 26;
    localparam int unsigned NUM_PORTS   = 2;
    localparam int unsigned MAX_PENDING = 4;

    logic                         i_clk;
    logic                         i_rst_n;
    logic [NUM_PORTS-1:0]         i_req;
    logic [NUM_PORTS-1:0]         i_we;
    logic [NUM_PORTS*ADDR_W-1:0]  i_addr;
    logic [NUM_PORTS*DATA_W-1:0]  i_wdata;
    logic [NUM_PORTS-1:0]         o_ready;
    logic [NUM_PORTS-1:0]         o_wdone;
    logic [NUM_PORTS-1:0]         o_rvalid;
    logic [DATA_W-1:0]            o_rdata;
    logic                         o_err;
    logic [ADDR_W-2:0]            o_avm_address;
    logic [AVM_DATA_W/8-1:0]      o_avm_byteenable;
    logic                         o_avm_chipselect;
    logic [AVM_DATA_W-1:0]        o_avm_writedata;
    logic                         o_avm_read;
    logic                         o_avm_write;
    logic [AVM_DATA_W-1:0]        i_avm_readdata;
    logic                         i_avm_readdatavalid;
    logic                         i_avm_waitrequest;

    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wd0, wd1;

    int n_vec;
    int n_err;

    assign i_addr  = {addr1, addr0};
    assign i_wdata = {wd1, wd0};

    sdram_avm_mport_bridge #(
        .DATA_W      (DATA_W),
        .AVM_DATA_W  (AVM_DATA_W),
        .ADDR_W      (ADDR_W),
        .NUM_PORTS   (NUM_PORTS),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_req               (i_req),
        .i_we                (i_we),
        .i_addr              (i_addr),
        .i_wdata             (i_wdata),
        .o_ready             (o_ready),
        .o_wdone             (o_wdone),
        .o_rvalid            (o_rvalid),
        .o_rdata             (o_rdata),
        .o_err               (o_err),
        .o_avm_address       (o_avm_address),
        .o_avm_byteenable    (o_avm_byteenable),
        .o_avm_chipselect    (o_avm_chipselect),
        .o_avm_writedata     (o_avm_writedata),
        .o_avm_read          (o_avm_read),
        .o_avm_write         (o_avm_write),
        .i_avm_readdata      (i_avm_readdata),
        .i_avm_readdatavalid (i_avm_readdatavalid),
        .i_avm_waitrequest   (i_avm_waitrequest)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 64'(o_ready), 64'h0);
        chk({tag, "_rd"},    64'(o_avm_read), 64'h0);
        chk({tag, "_wr"},    64'(o_avm_write), 64'h0);
        chk({tag, "_addr"},  64'(o_avm_address), 64'h0);
        chk({tag, "_be"},    64'(o_avm_byteenable), 64'h0);
        chk({tag, "_wd"},    64'(o_avm_writedata), 64'h0);
        chk({tag, "_rv"},    64'(o_rvalid), 64'h0);
        chk({tag, "_rdat"},  64'(o_rdata), 64'h0);
        chk({tag, "_wdn"},   64'(o_wdone), 64'h0);
        chk({tag, "_err"},   64'(o_err), 64'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        i_rst_n = 1'b0;
        i_req = '0;
        i_we = '0;
        addr0 = '0;
        addr1 = '0;
        wd0 = '0;
        wd1 = '0;
        i_avm_readdata = '0;
        i_avm_readdatavalid = 1'b0;
        i_avm_waitrequest = 1'b0;

        // Reset state
        repeat (2) step();
        chk_idle("rst");
        chk("rst_cs", 64'(o_avm_chipselect), 64'h1);
        i_rst_n = 1'b1;
        step();

        // 1: port0 write, addr 5 -> word 2, upper lane
        i_req = 2'b01; i_we = 2'b01; addr0 = 26'h5; wd0 = 16'hBEEF;
        #1 chk("t1_ready", 64'(o_ready), 64'h1);
        step();
        i_req = '0;
        chk("t1_wr",   64'(o_avm_write), 64'h1);
        chk("t1_rd",   64'(o_avm_read), 64'h0);
        chk("t1_addr", 64'(o_avm_address), 64'h2);
        chk("t1_be",   64'(o_avm_byteenable), 64'hC);
        chk("t1_wd",   64'(o_avm_writedata), 64'hBEEF0000);
        chk("t1_wdn0", 64'(o_wdone), 64'h0);
        step();
        chk("t1_wdn",  64'(o_wdone), 64'h1);
        chk("t1_wr2",  64'(o_avm_write), 64'h0);

        // 2: port1 read addr 4, return 0x12345678 -> lane 0
        i_req = 2'b10; i_we = 2'b00; addr1 = 26'h4;
        #1 chk("t2_ready", 64'(o_ready), 64'h2);
        step();
        i_req = '0;
        chk("t2_rd",   64'(o_avm_read), 64'h1);
        chk("t2_addr", 64'(o_avm_address), 64'h2);
        chk("t2_be",   64'(o_avm_byteenable), 64'h3);
        step();
        step();
        i_avm_readdatavalid = 1'b1; i_avm_readdata = 32'h12345678;
        chk("t2_rv0", 64'(o_rvalid), 64'h0);
        step();
        i_avm_readdatavalid = 1'b0;
        chk("t2_rv",   64'(o_rvalid), 64'h2);
        chk("t2_rdat", 64'(o_rdata), 64'h5678);
        step();
        chk("t2_rv1",  64'(o_rvalid), 64'h0);

        // 3+5: both ports read, grants 0,1,0 with a 3-cycle stall
        i_req = 2'b11; i_we = 2'b00; addr0 = 26'h0; addr1 = 26'h1;
        #1 chk("t3_g0", 64'(o_ready), 64'h1);
        step();
        chk("t3_addr0", 64'(o_avm_address), 64'h0);
        chk("t3_be0",   64'(o_avm_byteenable), 64'h3);
        addr0 = 26'h2;
        #1 chk("t3_g1", 64'(o_ready), 64'h2);
        step();
        chk("t3_addr1", 64'(o_avm_address), 64'h0);
        chk("t3_be1",   64'(o_avm_byteenable), 64'hC);
        i_avm_waitrequest = 1'b1;
        #1 chk("t3_stall_rdy", 64'(o_ready), 64'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t3_hold_rd",   64'(o_avm_read), 64'h1);
            chk("t3_hold_addr", 64'(o_avm_address), 64'h0);
            chk("t3_hold_be",   64'(o_avm_byteenable), 64'hC);
            chk("t3_hold_rdy",  64'(o_ready), 64'h0);
        end
        i_avm_waitrequest = 1'b0;
        #1 chk("t3_g2", 64'(o_ready), 64'h1);
        step();
        i_req = '0;
        chk("t3_addr2", 64'(o_avm_address), 64'h1);
        chk("t3_be2",   64'(o_avm_byteenable), 64'h3);
        chk("t3_rd2",   64'(o_avm_read), 64'h1);
        step();
        i_avm_readdatavalid = 1'b1; i_avm_readdata = 32'hAAAA0001;
        step();
        chk("t5_rv0", 64'(o_rvalid), 64'h1);
        chk("t5_rd0", 64'(o_rdata), 64'h0001);
        i_avm_readdata = 32'hBBBB0002;
        step();
        chk("t5_rv1", 64'(o_rvalid), 64'h2);
        chk("t5_rd1", 64'(o_rdata), 64'hBBBB);
        i_avm_readdata = 32'hCCCC0003;
        step();
        i_avm_readdatavalid = 1'b0;
        chk("t5_rv2", 64'(o_rvalid), 64'h1);
        chk("t5_rd2", 64'(o_rdata), 64'h0003);
        step();
        chk("t5_rv3", 64'(o_rvalid), 64'h0);

        // 4: fill 4 outstanding reads from port0, then a port1 write
        i_req = 2'b01; i_we = 2'b00; addr0 = 26'h6;
        for (int c = 0; c < 4; c++) begin
            #1 chk("t4_fill_rdy", 64'(o_ready), 64'h1);
            step();
        end
        #1 chk("t4_full_rdy", 64'(o_ready), 64'h0);
        i_req = 2'b11; i_we = 2'b10; addr1 = 26'h3; wd1 = 16'h1234;
        #1 chk("t4_wr_rdy", 64'(o_ready), 64'h2);
        step();
        i_req = 2'b01; i_we = 2'b00;
        i_avm_readdatavalid = 1'b1; i_avm_readdata = 32'h00009999;
        #1 chk("t4_full_rdv_rdy", 64'(o_ready), 64'h0);
        chk("t4_wr",   64'(o_avm_write), 64'h1);
        chk("t4_addr", 64'(o_avm_address), 64'h1);
        chk("t4_be",   64'(o_avm_byteenable), 64'hC);
        chk("t4_wd",   64'(o_avm_writedata), 64'h12340000);
        step();
        i_avm_readdatavalid = 1'b0;
        chk("t4_rv",   64'(o_rvalid), 64'h1);
        chk("t4_rdat", 64'(o_rdata), 64'h9999);
        chk("t4_wdn",  64'(o_wdone), 64'h2);
        #1 chk("t4_reopen", 64'(o_ready), 64'h1);
        i_req = '0;
        i_avm_readdatavalid = 1'b1; i_avm_readdata = 32'h0;
        repeat (3) step();
        i_avm_readdatavalid = 1'b0;
        chk("t4_drain_rv", 64'(o_rvalid), 64'h1);
        chk("t4_err", 64'(o_err), 64'h0);
        step();

        // 6: stray return, then reset with 2 reads outstanding
        i_avm_readdatavalid = 1'b1; i_avm_readdata = 32'hDEADDEAD;
        step();
        i_avm_readdatavalid = 1'b0;
        chk("t6_err", 64'(o_err), 64'h1);
        chk("t6_rv",  64'(o_rvalid), 64'h0);
        step();
        chk("t6_sticky", 64'(o_err), 64'h1);
        i_req = 2'b11; i_we = 2'b00; addr0 = 26'h8; addr1 = 26'h9;
        step();
        step();
        i_req = '0;
        step();
        i_rst_n = 1'b0;
        #1 chk_idle("t6_rst");
        step();
        i_rst_n = 1'b1;
        i_avm_readdatavalid = 1'b1; i_avm_readdata = 32'hFFFFFFFF;
        step();
        i_avm_readdatavalid = 1'b0;
        chk("t6_late_rv", 64'(o_rvalid), 64'h0);
        chk("t6_late_err", 64'(o_err), 64'h1);

        // Post-reset read from port1, odd address -> upper lane
        i_req = 2'b10; addr1 = 26'h1;
        #1 chk("t6_post_rdy", 64'(o_ready), 64'h2);
        step();
        i_req = '0;
        i_avm_readdatavalid = 1'b1; i_avm_readdata = 32'h55556666;
        step();
        i_avm_readdatavalid = 1'b0;
        chk("t6_post_rv",   64'(o_rvalid), 64'h2);
        chk("t6_post_rdat", 64'(o_rdata), 64'h5555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
